// File: rtl/accum_bank_nl_pkg.sv
// Shared parameters, lane types and the rounding/saturation helper for the
// accumulator bank.
package conv_nl_pkg;

    localparam int LANES_DEF  = 4;
    localparam int ACC_W_DEF  = 32;
    localparam int OUT_W_DEF  = 8;
    localparam int ADDR_W_DEF = 16;

    // Working width of the quantiser; wide enough for any ACC_W up to 32
    // plus the rounding constant without overflow.
    localparam int QW = 64;

    typedef logic signed [ACC_W_DEF-1:0] lane_acc_t;
    typedef logic        [OUT_W_DEF-1:0] lane_out_t;

    // Optional ReLU, round-half-up arithmetic shift, then clamp to the
    // signed or unsigned OUT_W range. Shifts of acc_w or more collapse to
    // the sign of the (post-ReLU) value.
    function automatic logic signed [QW-1:0] sat_round(
        input logic signed [QW-1:0] v_in,
        input logic        [5:0]    shift,
        input logic                 relu,
        input int                   acc_w,
        input int                   out_w
    );
        logic signed [QW-1:0] v;
        logic signed [QW-1:0] hi;
        logic signed [QW-1:0] lo;
        v = (relu && (v_in < 0)) ? '0 : v_in;
        if (int'(shift) >= acc_w) begin
            v = (v < 0) ? -64'sd1 : 64'sd0;
        end else if (shift != 6'd0) begin
            v = (v + (64'sd1 <<< (shift - 6'd1))) >>> shift;
        end
        hi = relu ? ((64'sd1 <<< out_w) - 64'sd1) : ((64'sd1 <<< (out_w - 1)) - 64'sd1);
        lo = relu ? 64'sd0 : -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            v = hi;
        end else if (v < lo) begin
            v = lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/accum_bank_nl_if.sv
// Beat input, psum BRAM ports and output-memory write port of the
// accumulator bank. slave = the bank, master = the surrounding datapath.
interface accum_bank_nl_if
    import conv_nl_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic                     in_valid;
    logic                     in_first;
    logic                     in_last;
    logic [ADDR_W-1:0]        in_addr;
    logic [LANES*ACC_W-1:0]   in_data;

    logic [ADDR_W-1:0]        psum_rd_addr;
    logic [LANES*ACC_W-1:0]   psum_rd_data;
    logic                     psum_we;
    logic [ADDR_W-1:0]        psum_wr_addr;
    logic [LANES*ACC_W-1:0]   psum_wr_data;

    logic                     out_we;
    logic [ADDR_W-1:0]        out_addr;
    logic [LANES*OUT_W-1:0]   out_data;

    modport slave (
        input  in_valid, in_first, in_last, in_addr, in_data, psum_rd_data,
        output psum_rd_addr, psum_we, psum_wr_addr, psum_wr_data,
        output out_we, out_addr, out_data
    );

    modport master (
        output in_valid, in_first, in_last, in_addr, in_data, psum_rd_data,
        input  psum_rd_addr, psum_we, psum_wr_addr, psum_wr_data,
        input  out_we, out_addr, out_data
    );
endinterface

// File: rtl/acc_lane_quant.sv
// One lane: choose the accumulation base, add the partial sum, quantise.
module acc_lane_quant
    import conv_nl_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             first,
    input  logic             fwd_s2,
    input  logic             fwd_shadow,
    input  logic [ACC_W-1:0] bias,
    input  logic [ACC_W-1:0] rd_data,
    input  logic [ACC_W-1:0] s2_data,
    input  logic [ACC_W-1:0] shadow_data,
    input  logic [ACC_W-1:0] data,
    input  logic             relu_en,
    input  logic [5:0]       shift,
    output logic [ACC_W-1:0] sum,
    output logic [OUT_W-1:0] quant
);
    logic [ACC_W-1:0]     base;
    logic signed [QW-1:0] sum_ext;

    // Base is the bias on the first channel, else the newest psum value:
    // in-flight write beats the shadowed write beats the (stale) BRAM read.
    always_comb begin
        base = rd_data;
        if (first) begin
            base = bias;
        end else if (fwd_s2) begin
            base = s2_data;
        end else if (fwd_shadow) begin
            base = shadow_data;
        end
    end

    assign sum     = base + data;
    assign sum_ext = QW'(signed'(sum));
    assign quant   = OUT_W'(sat_round(sum_ext, shift, relu_en, ACC_W, OUT_W));
endmodule

// File: rtl/accum_bank_nl.sv
// Multi-lane psum accumulator: bias on the first channel, read-modify-write
// of an external psum BRAM on middle channels, quantised packed output on
// the last channel. Two-stage pipeline, one beat per cycle, no backpressure.
module accum_bank_nl
    import conv_nl_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_relu_en,
    input  logic [5:0]       cfg_shift,
    input  logic             bias_push,
    input  logic [ACC_W-1:0] bias_in,
    accum_bank_nl_if.slave   bus,
    output logic             busy,
    output logic [31:0]      out_count
);
    logic                   s1_valid, s1_first, s1_last;
    logic [ADDR_W-1:0]      s1_addr;
    logic [LANES*ACC_W-1:0] s1_data;

    logic                   s2_valid;
    logic                   psum_we_q, out_we_q;
    logic [ADDR_W-1:0]      psum_wr_addr_q, out_addr_q;
    logic [LANES*ACC_W-1:0] psum_wr_data_q;
    logic [LANES*OUT_W-1:0] out_data_q;

    logic                   shadow_valid;
    logic [ADDR_W-1:0]      shadow_addr;
    logic [LANES*ACC_W-1:0] shadow_data;

    logic [ACC_W-1:0]       bias [LANES];

    logic                   fwd_s2, fwd_shadow;
    logic [LANES*ACC_W-1:0] sums;
    logic [LANES*OUT_W-1:0] quants;

    assign bus.psum_rd_addr = bus.in_addr;
    assign bus.psum_we      = psum_we_q;
    assign bus.psum_wr_addr = psum_wr_addr_q;
    assign bus.psum_wr_data = psum_wr_data_q;
    assign bus.out_we       = out_we_q;
    assign bus.out_addr     = out_addr_q;
    assign bus.out_data     = out_data_q;
    assign busy             = s1_valid | s2_valid;

    assign fwd_s2     = psum_we_q    && (psum_wr_addr_q == s1_addr);
    assign fwd_shadow = shadow_valid && (shadow_addr    == s1_addr);

    // Bias shift chain: new values enter at the top lane and walk down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) bias[i] <= '0;
        end else if (bias_push) begin
            bias[LANES-1] <= bias_in;
            for (int i = 0; i < LANES - 1; i++) bias[i] <= bias[i+1];
        end
    end

    // S1 capture: the BRAM read issued this edge lands alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            s1_first <= bus.in_first;
            s1_last  <= bus.in_last;
            s1_addr  <= bus.in_addr;
            s1_data  <= bus.in_data;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        acc_lane_quant #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane (
            .first       (s1_first),
            .fwd_s2      (fwd_s2),
            .fwd_shadow  (fwd_shadow),
            .bias        (bias[l]),
            .rd_data     (bus.psum_rd_data[(LANES-1-l)*ACC_W +: ACC_W]),
            .s2_data     (psum_wr_data_q[(LANES-1-l)*ACC_W +: ACC_W]),
            .shadow_data (shadow_data[(LANES-1-l)*ACC_W +: ACC_W]),
            .data        (s1_data[(LANES-1-l)*ACC_W +: ACC_W]),
            .relu_en     (cfg_relu_en),
            .shift       (cfg_shift),
            .sum         (sums[(LANES-1-l)*ACC_W +: ACC_W]),
            .quant       (quants[(LANES-1-l)*OUT_W +: OUT_W])
        );
    end

    // S2 registered writes: psum on non-last beats, packed output on last.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid       <= 1'b0;
            psum_we_q      <= 1'b0;
            out_we_q       <= 1'b0;
            psum_wr_addr_q <= '0;
            psum_wr_data_q <= '0;
            out_addr_q     <= '0;
            out_data_q     <= '0;
            out_count      <= '0;
        end else begin
            s2_valid  <= s1_valid;
            psum_we_q <= s1_valid && !s1_last;
            out_we_q  <= s1_valid && s1_last;
            if (s1_valid && !s1_last) begin
                psum_wr_addr_q <= s1_addr;
                psum_wr_data_q <= sums;
            end
            if (s1_valid && s1_last) begin
                out_addr_q <= s1_addr;
                out_data_q <= quants;
                out_count  <= out_count + 32'd1;
            end
        end
    end

    // Shadow of last cycle's psum write, which a read-first BRAM misses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_valid <= 1'b0;
            shadow_addr  <= '0;
            shadow_data  <= '0;
        end else begin
            shadow_valid <= psum_we_q;
            shadow_addr  <= psum_wr_addr_q;
            shadow_data  <= psum_wr_data_q;
        end
    end
endmodule

// File: tb/tb_accum_bank_nl.sv
// Scoreboard bench: two builds (4x32 and 8x24 lanes), read-first BRAM models,
// expected psum/output writes queued at issue and checked by a monitor.
module tb_accum_bank_nl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        relu_a, relu_b;
    logic [5:0]  shift_a, shift_b;
    logic        bias_push_a, bias_push_b;
    logic [31:0] bias_in_a;
    logic [23:0] bias_in_b;
    logic        busy_a, busy_b;
    logic [31:0] cnt_a, cnt_b;

    accum_bank_nl_if #(.LANES(4), .ACC_W(32), .OUT_W(8), .ADDR_W(16)) ifa ();
    accum_bank_nl_if #(.LANES(8), .ACC_W(24), .OUT_W(8), .ADDR_W(16)) ifb ();

    accum_bank_nl #(.LANES(4), .ACC_W(32), .OUT_W(8), .ADDR_W(16)) dut_a (
        .clk(clk), .rst(rst_n), .cfg_relu_en(relu_a), .cfg_shift(shift_a),
        .bias_push(bias_push_a), .bias_in(bias_in_a), .bus(ifa),
        .busy(busy_a), .out_count(cnt_a)
    );

    accum_bank_nl #(.LANES(8), .ACC_W(24), .OUT_W(8), .ADDR_W(16)) dut_b (
        .clk(clk), .rst(rst_n), .cfg_relu_en(relu_b), .cfg_shift(shift_b),
        .bias_push(bias_push_b), .bias_in(bias_in_b), .bus(ifb),
        .busy(busy_b), .out_count(cnt_b)
    );

    // read-first BRAM models
    logic [127:0] mem_a [0:255];
    logic [191:0] mem_b [0:255];
    always @(posedge clk) begin
        ifa.psum_rd_data <= mem_a[ifa.psum_rd_addr[7:0]];
        if (ifa.psum_we) mem_a[ifa.psum_wr_addr[7:0]] <= ifa.psum_wr_data;
        ifb.psum_rd_data <= mem_b[ifb.psum_rd_addr[7:0]];
        if (ifb.psum_we) mem_b[ifb.psum_wr_addr[7:0]] <= ifb.psum_wr_data;
    end

    typedef struct {
        logic [15:0]  addr;
        logic [191:0] data;
    } exp_t;

    exp_t qpa[$], qoa[$], qpb[$], qob[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [191:0] act, input logic [191:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name, input logic [15:0] addr);
        checks++;
        errors++;
        $display("FAIL %s actual=write@%0h required=no write", name, addr);
    endtask

    // monitor: pop and compare whenever a write enable is presented
    always @(negedge clk) begin
        if (ifa.psum_we === 1'b1) begin
            if (qpa.size() == 0) unexpected("a_psum", ifa.psum_wr_addr);
            else begin
                e = qpa.pop_front();
                cmp("a_psum_addr", 192'(ifa.psum_wr_addr), 192'(e.addr));
                cmp("a_psum_data", 192'(ifa.psum_wr_data), e.data);
            end
        end
        if (ifa.out_we === 1'b1) begin
            if (qoa.size() == 0) unexpected("a_out", ifa.out_addr);
            else begin
                e = qoa.pop_front();
                cmp("a_out_addr", 192'(ifa.out_addr), 192'(e.addr));
                cmp("a_out_data", 192'(ifa.out_data), e.data);
            end
        end
        if (ifb.psum_we === 1'b1) begin
            if (qpb.size() == 0) unexpected("b_psum", ifb.psum_wr_addr);
            else begin
                e = qpb.pop_front();
                cmp("b_psum_addr", 192'(ifb.psum_wr_addr), 192'(e.addr));
                cmp("b_psum_data", 192'(ifb.psum_wr_data), e.data);
            end
        end
        if (ifb.out_we === 1'b1) begin
            if (qob.size() == 0) unexpected("b_out", ifb.out_addr);
            else begin
                e = qob.pop_front();
                cmp("b_out_addr", 192'(ifb.out_addr), 192'(e.addr));
                cmp("b_out_data", 192'(ifb.out_data), e.data);
            end
        end
    end

    function automatic logic [127:0] p4(input logic [31:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_bias_a(input logic [31:0] v);
        bias_push_a = 1'b1;
        bias_in_a   = v;
        @(posedge clk);
        #1;
        bias_push_a = 1'b0;
    endtask

    task automatic drive_a(input logic f, input logic l, input logic [15:0] a, input logic [127:0] d);
        ifa.in_valid = 1'b1;
        ifa.in_first = f;
        ifa.in_last  = l;
        ifa.in_addr  = a;
        ifa.in_data  = d;
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
    endtask

    task automatic drive_b(input logic f, input logic l, input logic [15:0] a, input logic [191:0] d);
        ifb.in_valid = 1'b1;
        ifb.in_first = f;
        ifb.in_last  = l;
        ifb.in_addr  = a;
        ifb.in_data  = d;
        @(posedge clk);
        #1;
        ifb.in_valid = 1'b0;
    endtask

    task automatic exp_pa(input logic [15:0] a, input logic [127:0] d);
        qpa.push_back('{addr: a, data: 192'(d)});
    endtask

    task automatic exp_oa(input logic [15:0] a, input logic [31:0] d);
        qoa.push_back('{addr: a, data: 192'(d)});
    endtask

    logic [191:0] db;

    initial begin
        rst_n = 1'b0;
        relu_a = 1'b0; relu_b = 1'b0;
        shift_a = 6'd0; shift_b = 6'd0;
        bias_push_a = 1'b0; bias_push_b = 1'b0;
        bias_in_a = '0; bias_in_b = '0;
        ifa.in_valid = 1'b0; ifa.in_first = 1'b0; ifa.in_last = 1'b0;
        ifa.in_addr = 16'h1234; ifa.in_data = '0;
        ifb.in_valid = 1'b0; ifb.in_first = 1'b0; ifb.in_last = 1'b0;
        ifb.in_addr = 16'h0000; ifb.in_data = '0;

        repeat (2) @(posedge clk);
        #1;
        cmp("rst_psum_we", 192'(ifa.psum_we), 192'd0);
        cmp("rst_out_we", 192'(ifa.out_we), 192'd0);
        cmp("rst_busy", 192'(busy_a), 192'd0);
        cmp("rst_count", 192'(cnt_a), 192'd0);
        cmp("rd_addr_comb", 192'(ifa.psum_rd_addr), 192'h1234);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // bias + single first&last beat
        push_bias_a(32'd10); push_bias_a(32'd20); push_bias_a(32'd30); push_bias_a(32'd40);
        exp_oa(16'd5, 32'h0B151F29);
        drive_a(1'b1, 1'b1, 16'd5, p4(1, 1, 1, 1));
        idle(3);
        cmp("a_count_first_last", 192'(cnt_a), 192'd1);
        cmp("a_idle_busy", 192'(busy_a), 192'd0);
        repeat (4) push_bias_a(32'd0);

        // three-channel accumulation through the BRAM
        shift_a = 6'd2;
        exp_pa(16'd3, p4(100, 100, 100, 100));
        drive_a(1'b1, 1'b0, 16'd3, p4(100, 100, 100, 100));
        idle(3);
        exp_pa(16'd3, p4(200, 200, 200, 200));
        drive_a(1'b0, 1'b0, 16'd3, p4(100, 100, 100, 100));
        idle(3);
        exp_oa(16'd3, 32'h4B4B4B4B);
        drive_a(1'b0, 1'b1, 16'd3, p4(100, 100, 100, 100));
        idle(3);

        // forwarding: back-to-back (S2 path), then one-cycle gaps (shadow path)
        shift_a = 6'd0;
        exp_pa(16'd7, p4(1, 2, 3, 4));
        drive_a(1'b1, 1'b0, 16'd7, p4(1, 2, 3, 4));
        exp_pa(16'd7, p4(11, 22, 33, 44));
        drive_a(1'b0, 1'b0, 16'd7, p4(10, 20, 30, 40));
        exp_pa(16'd7, p4(111, 122, 133, 144));
        drive_a(1'b0, 1'b0, 16'd7, p4(100, 100, 100, 100));
        idle(1);
        exp_pa(16'd7, p4(112, 123, 134, 145));
        drive_a(1'b0, 1'b0, 16'd7, p4(1, 1, 1, 1));
        idle(1);
        exp_oa(16'd7, 32'h707B7F7F);
        drive_a(1'b0, 1'b1, 16'd7, p4(0, 0, 0, 0));
        idle(3);

        // saturation, ReLU, large shift, round half up
        exp_oa(16'd4, 32'h807F807F);
        drive_a(1'b1, 1'b1, 16'd4, p4(-500, 1000, -500, 1000));
        idle(3);
        relu_a = 1'b1;
        exp_oa(16'd4, 32'h00FF00FF);
        drive_a(1'b1, 1'b1, 16'd4, p4(-500, 1000, -500, 1000));
        idle(3);
        relu_a = 1'b0;
        shift_a = 6'd40;
        exp_oa(16'd8, 32'hFF00FF00);
        drive_a(1'b1, 1'b1, 16'd8, p4(-500, 1000, -1, 5));
        idle(3);
        shift_a = 6'd1;
        exp_oa(16'd9, 32'h02FF03FE);
        drive_a(1'b1, 1'b1, 16'd9, p4(3, -3, 5, -5));
        idle(3);
        shift_a = 6'd0;
        cmp("a_count_total", 192'(cnt_a), 192'd7);

        // 8-lane, 24-bit build: lane 0 must occupy the MSBs
        db = {24'd3, 24'd6, 24'd9, 24'd12, 24'd15, 24'd18, 24'd21, 24'd24};
        qpb.push_back('{addr: 16'd2, data: db});
        drive_b(1'b1, 1'b0, 16'd2, db);
        idle(3);
        qob.push_back('{addr: 16'd2, data: 192'(64'h0306090C0F121518)});
        drive_b(1'b0, 1'b1, 16'd2, 192'd0);
        idle(3);
        qob.push_back('{addr: 16'd6, data: 192'(64'h0306090C0F121518)});
        drive_b(1'b1, 1'b1, 16'd6, db);
        idle(3);
        cmp("b_count_total", 192'(cnt_b), 192'd2);

        // reset with one beat in S2 and one in S1: nothing may complete
        drive_a(1'b1, 1'b0, 16'd12, p4(1, 1, 1, 1));
        drive_a(1'b1, 1'b1, 16'd13, p4(1, 1, 1, 1));
        #1;
        rst_n = 1'b0;
        #1;
        cmp("mid_rst_psum_we", 192'(ifa.psum_we), 192'd0);
        cmp("mid_rst_out_we", 192'(ifa.out_we), 192'd0);
        cmp("mid_rst_busy", 192'(busy_a), 192'd0);
        cmp("mid_rst_count_a", 192'(cnt_a), 192'd0);
        cmp("mid_rst_count_b", 192'(cnt_b), 192'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp("post_rst_no_write", 192'({ifa.psum_we, ifa.out_we}), 192'd0);
        end
        idle(2);

        cmp("qpa_drained", 192'(qpa.size()), 192'd0);
        cmp("qoa_drained", 192'(qoa.size()), 192'd0);
        cmp("qpb_drained", 192'(qpb.size()), 192'd0);
        cmp("qob_drained", 192'(qob.size()), 192'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
